// File: rtl/reset_sequencer.sv
// Staged system reset generator: stretches a watchdog or software trigger, then releases stages in order.
// Optional input synchronizers are enabled by defining RST_SEQ_SYNC_EN.
module reset_sequencer #(
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGE_GAP      = 4,
    parameter int NUM_STAGES     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wdt_reset,
    input  logic                  sw_req,
    input  logic                  clear_cause,
    output logic [NUM_STAGES-1:0] sys_rst_out,
    output logic                  seq_busy,
    output logic [1:0]            rst_cause,
    output logic [7:0]            wdt_count
);

    localparam int MAX_CNT = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;
    localparam logic [CNT_W-1:0]      STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0]      GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [NUM_STAGES-1:0] ALL_ONES     = '1;
    localparam logic [NUM_STAGES-1:0] LAST_STAGE   = NUM_STAGES'(1) << (NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_IDLE
    } state_t;

    state_t                  state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [NUM_STAGES-1:0]   out_n;
    logic                    wdt_in, sw_in, wdt_prev;
    logic                    wdt_trig, trig;

`ifdef RST_SEQ_SYNC_EN
    logic [1:0] wdt_sync, sw_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_sync <= 2'b00;
            sw_sync  <= 2'b00;
        end else begin
            wdt_sync <= {wdt_sync[0], wdt_reset};
            sw_sync  <= {sw_sync[0], sw_req};
        end
    end

    assign wdt_in = wdt_sync[1];
    assign sw_in  = sw_sync[1];
`else
    assign wdt_in = wdt_reset;
    assign sw_in  = sw_req;
`endif

    assign wdt_trig = wdt_in & ~wdt_prev;
    assign trig     = wdt_trig | sw_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_ASSERT;
            cnt         <= '0;
            sys_rst_out <= ALL_ONES;
            seq_busy    <= 1'b1;
            wdt_prev    <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            sys_rst_out <= out_n;
            seq_busy    <= |out_n;
            wdt_prev    <= wdt_in;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        out_n   = sys_rst_out;
        case (state)
            ST_ASSERT: begin
                out_n = ALL_ONES;
                if (trig) begin
                    cnt_n = '0;
                end else if (cnt == STRETCH_LAST) begin
                    // A watchdog still holding its timeout keeps everything in reset.
                    if (!wdt_in) begin
                        cnt_n = '0;
                        if (NUM_STAGES == 1) begin
                            state_n = ST_IDLE;
                            out_n   = '0;
                        end else begin
                            state_n = ST_RELEASE;
                            out_n   = ALL_ONES << 1;
                        end
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (trig) begin
                    state_n = ST_ASSERT;
                    out_n   = ALL_ONES;
                    cnt_n   = '0;
                end else if (cnt == GAP_LAST) begin
                    cnt_n = '0;
                    out_n = sys_rst_out << 1;
                    if (sys_rst_out == LAST_STAGE) begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                out_n = '0;
                if (trig) begin
                    state_n = ST_ASSERT;
                    out_n   = ALL_ONES;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = ST_ASSERT;
                out_n   = ALL_ONES;
                cnt_n   = '0;
            end
        endcase
    end

    // Diagnostics: a trigger in the same cycle overrides clear_cause.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_cause <= 2'b00;
            wdt_count <= 8'd0;
        end else if (wdt_trig) begin
            rst_cause <= 2'b01;
            if (wdt_count != 8'hFF) begin
                wdt_count <= wdt_count + 8'd1;
            end
        end else if (sw_in) begin
            rst_cause <= 2'b10;
        end else if (clear_cause) begin
            rst_cause <= 2'b00;
            wdt_count <= 8'd0;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed vector tables, async reset cases, and random stimulus against a timing model.
module tb_reset_sequencer;

    localparam int S  = 16;
    localparam int G  = 4;
    localparam int NS = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wdt_reset = 1'b0;
    logic          sw_req = 1'b0;
    logic          clear_cause = 1'b0;
    logic [NS-1:0] sys_rst_out;
    logic          seq_busy;
    logic [1:0]    rst_cause;
    logic [7:0]    wdt_count;

    int total = 0;
    int bad   = 0;

    reset_sequencer #(.STRETCH_CYCLES(S), .STAGE_GAP(G), .NUM_STAGES(NS)) dut (
        .clk         (clk),
        .rst         (rst),
        .wdt_reset   (wdt_reset),
        .sw_req      (sw_req),
        .clear_cause (clear_cause),
        .sys_rst_out (sys_rst_out),
        .seq_busy    (seq_busy),
        .rst_cause   (rst_cause),
        .wdt_count   (wdt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        bit         w;
        bit         s;
        bit         c;
        logic [2:0] out;
        bit         busy;
        logic [1:0] cause;
        logic [7:0] cnt;
    } vec_t;

    vec_t por_tab[7];
    vec_t dir_tab[$];

    function automatic vec_t mk(int n, bit w, bit s, bit c, logic [2:0] out, bit busy,
                                logic [1:0] cause, logic [7:0] cnt);
        vec_t v;
        v.n = n; v.w = w; v.s = s; v.c = c;
        v.out = out; v.busy = busy; v.cause = cause; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input bit w, input bit s, input bit c);
        wdt_reset   = w;
        sw_req      = s;
        clear_cause = c;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_row(input vec_t v, input string tag);
        repeat (v.n) tick(v.w, v.s, v.c);
        chk({tag, ".out"},   32'(sys_rst_out), 32'(v.out));
        chk({tag, ".busy"},  32'(seq_busy),    32'(v.busy));
        chk({tag, ".cause"}, 32'(rst_cause),   32'(v.cause));
        chk({tag, ".cnt"},   32'(wdt_count),   32'(v.cnt));
    endtask

    // Reference model: tracks the edge where the stretch started and the edge stage 0 dropped.
    int         m_e, m_start, m_rel;
    bit         m_prev;
    logic [1:0] m_cause;
    int         m_cnt;

    task automatic model_reset();
        m_e = 0; m_start = 0; m_rel = -1; m_prev = 1'b0; m_cause = 2'b00; m_cnt = 0;
    endtask

    task automatic model_step(input bit w, input bit s, input bit c);
        bit wt;
        m_e++;
        wt = w && !m_prev;
        m_prev = w;
        if (wt || s) begin
            m_start = m_e;
            m_rel   = -1;
        end else if (m_rel < 0 && m_e >= m_start + S && !w) begin
            m_rel = m_e;
        end
        if (wt) begin
            m_cause = 2'b01;
            if (m_cnt < 255) m_cnt++;
        end else if (s) begin
            m_cause = 2'b10;
        end else if (c) begin
            m_cause = 2'b00;
            m_cnt   = 0;
        end
    endtask

    function automatic logic [NS-1:0] model_out();
        int k;
        logic [NS-1:0] ones;
        ones = '1;
        if (m_rel < 0) return ones;
        k = 1 + (m_e - m_rel) / G;
        if (k >= NS) return '0;
        return ones << k;
    endfunction

    initial begin
        bit w, s, c;
        logic [NS-1:0] eo;

        por_tab[0] = mk(15, 0, 0, 0, 3'b111, 1, 2'b00, 8'd0);
        por_tab[1] = mk(1,  0, 0, 0, 3'b110, 1, 2'b00, 8'd0);
        por_tab[2] = mk(3,  0, 0, 0, 3'b110, 1, 2'b00, 8'd0);
        por_tab[3] = mk(1,  0, 0, 0, 3'b100, 1, 2'b00, 8'd0);
        por_tab[4] = mk(3,  0, 0, 0, 3'b100, 1, 2'b00, 8'd0);
        por_tab[5] = mk(1,  0, 0, 0, 3'b000, 0, 2'b00, 8'd0);
        por_tab[6] = mk(4,  0, 0, 0, 3'b000, 0, 2'b00, 8'd0);

        // single watchdog pulse from idle
        dir_tab.push_back(mk(1,  1, 0, 0, 3'b111, 1, 2'b01, 8'd1));
        dir_tab.push_back(mk(15, 0, 0, 0, 3'b111, 1, 2'b01, 8'd1));
        dir_tab.push_back(mk(1,  0, 0, 0, 3'b110, 1, 2'b01, 8'd1));
        dir_tab.push_back(mk(4,  0, 0, 0, 3'b100, 1, 2'b01, 8'd1));
        dir_tab.push_back(mk(4,  0, 0, 0, 3'b000, 0, 2'b01, 8'd1));
        // software request aborts an in-progress release
        dir_tab.push_back(mk(1,  1, 0, 0, 3'b111, 1, 2'b01, 8'd2));
        dir_tab.push_back(mk(16, 0, 0, 0, 3'b110, 1, 2'b01, 8'd2));
        dir_tab.push_back(mk(2,  0, 0, 0, 3'b110, 1, 2'b01, 8'd2));
        dir_tab.push_back(mk(1,  0, 1, 0, 3'b111, 1, 2'b10, 8'd2));
        dir_tab.push_back(mk(15, 0, 0, 0, 3'b111, 1, 2'b10, 8'd2));
        dir_tab.push_back(mk(1,  0, 0, 0, 3'b110, 1, 2'b10, 8'd2));
        dir_tab.push_back(mk(4,  0, 0, 0, 3'b100, 1, 2'b10, 8'd2));
        dir_tab.push_back(mk(4,  0, 0, 0, 3'b000, 0, 2'b10, 8'd2));
        // watchdog held high for 40 cycles
        dir_tab.push_back(mk(40, 1, 0, 0, 3'b111, 1, 2'b01, 8'd3));
        dir_tab.push_back(mk(1,  0, 0, 0, 3'b110, 1, 2'b01, 8'd3));
        dir_tab.push_back(mk(4,  0, 0, 0, 3'b100, 1, 2'b01, 8'd3));
        dir_tab.push_back(mk(4,  0, 0, 0, 3'b000, 0, 2'b01, 8'd3));
        // simultaneous triggers, clear, and trigger-beats-clear
        dir_tab.push_back(mk(1,  1, 1, 0, 3'b111, 1, 2'b01, 8'd4));
        dir_tab.push_back(mk(24, 0, 0, 0, 3'b000, 0, 2'b01, 8'd4));
        dir_tab.push_back(mk(1,  0, 0, 1, 3'b000, 0, 2'b00, 8'd0));
        dir_tab.push_back(mk(1,  0, 1, 0, 3'b111, 1, 2'b10, 8'd0));
        dir_tab.push_back(mk(24, 0, 0, 0, 3'b000, 0, 2'b10, 8'd0));
        dir_tab.push_back(mk(1,  1, 0, 1, 3'b111, 1, 2'b01, 8'd1));
        dir_tab.push_back(mk(24, 0, 0, 0, 3'b000, 0, 2'b01, 8'd1));

        repeat (2) @(posedge clk);
        #1;
        chk("por.out",   32'(sys_rst_out), 32'h7);
        chk("por.busy",  32'(seq_busy),    32'h1);
        chk("por.cause", 32'(rst_cause),   32'h0);
        chk("por.cnt",   32'(wdt_count),   32'h0);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) apply_row(por_tab[i], $sformatf("por%0d", i));
        for (int i = 0; i < dir_tab.size(); i++) apply_row(dir_tab[i], $sformatf("dir%0d", i));

        // watchdog count saturation, then clear from idle
        for (int i = 0; i < 300; i++) begin
            tick(1, 0, 0);
            tick(0, 0, 0);
        end
        chk("sat.cnt",   32'(wdt_count), 32'd255);
        chk("sat.cause", 32'(rst_cause), 32'h1);
        repeat (24) tick(0, 0, 0);
        chk("sat.idle", 32'(sys_rst_out), 32'h0);
        tick(0, 0, 1);
        chk("clr.cause", 32'(rst_cause), 32'h0);
        chk("clr.cnt",   32'(wdt_count), 32'h0);

        // asynchronous reset while only the last stage is held
        tick(1, 0, 0);
        repeat (20) tick(0, 0, 0);
        chk("mid.out", 32'(sys_rst_out), 32'h4);
        chk("mid.cnt", 32'(wdt_count),   32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst.out",   32'(sys_rst_out), 32'h7);
        chk("arst.busy",  32'(seq_busy),    32'h1);
        chk("arst.cause", 32'(rst_cause),   32'h0);
        chk("arst.cnt",   32'(wdt_count),   32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 7; i++) apply_row(por_tab[i], $sformatf("repor%0d", i));

        // randomized run against the reference model
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        w = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (w) w = ($urandom_range(0, 99) >= 30);
            else   w = ($urandom_range(0, 99) < 3);
            s = ($urandom_range(0, 99) < 3);
            c = !s && ($urandom_range(0, 99) < 3);
            tick(w, s, c);
            model_step(w, s, c);
            eo = model_out();
            chk("rnd.out",   32'(sys_rst_out), 32'(eo));
            chk("rnd.busy",  32'(seq_busy),    32'(eo != '0));
            chk("rnd.cause", 32'(rst_cause),   32'(m_cause));
            chk("rnd.cnt",   32'(wdt_count),   32'(m_cnt));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
